// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: full-duplex UART with RX and TX FIFOs on valid/ready byte ports.
// One shared tick divider drives both directions; RX uses oversampled mid-bit sampling.
// Optional build macro UART_PARITY_EN adds an even-parity bit and a sticky parity_err output.
module uart_fifo_bridge #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 clr_err,
  output logic                 frame_err,
  output logic                 rx_overrun
`ifdef UART_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          rx_meta, rxs;

  rx_state_t            rx_state, rx_next;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_at_sample, rx_push, ferr_set;

  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr, rx_rd;
  logic [AW:0]          rx_count;
  logic                 rx_full, rx_pop, rx_wr_en;

  tx_state_t            tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_at_end, tx_pop;

  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr, tx_rd;
  logic [AW:0]          tx_count;
  logic                 tx_full, tx_empty, tx_wr_en;

`ifdef UART_PARITY_EN
  logic rx_par, perr_set, tx_par;
`endif

  // Free-running divider producing a one-clock tick every DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchronizer for the asynchronous serial input, idling high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else rx_state <= rx_next;
  end

  // RX next-state: glitch rejection at mid-start, framing check at mid-stop
  always_comb begin
    rx_next  = rx_state;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_PARITY_EN
    perr_set = 1'b0;
`endif
    rx_at_sample = tick && (rx_cnt == ((rx_state == R_START) ? OS_MID : OS_LAST));
    case (rx_state)
      R_IDLE:      if (!rxs) rx_next = R_START;
      R_START:     if (rx_at_sample) rx_next = rxs ? R_IDLE : R_DATA;
      R_DATA: begin
        if (rx_at_sample && rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
          rx_next = R_PARITY;
`else
          rx_next = R_STOP;
`endif
        end
      end
      R_PARITY:    if (rx_at_sample) rx_next = R_STOP;
      R_STOP: begin
        if (rx_at_sample) begin
          if (rxs) begin
            rx_next = R_IDLE;
`ifdef UART_PARITY_EN
            if (rx_par != ^rx_shift) perr_set = 1'b1;
            else rx_push = 1'b1;
`else
            rx_push = 1'b1;
`endif
          end else begin
            ferr_set = 1'b1;
            rx_next  = R_WAIT_HIGH;
          end
        end
      end
      R_WAIT_HIGH: if (rxs) rx_next = R_IDLE;
      default:     rx_next = R_IDLE;
    endcase
  end

  // RX tick/bit counters and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else if (rx_state == R_IDLE || rx_state == R_WAIT_HIGH) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else if (tick) begin
      if (rx_at_sample) begin
        rx_cnt <= '0;
        if (rx_state == R_DATA) begin
          rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
`ifdef UART_PARITY_EN
        if (rx_state == R_PARITY) rx_par <= rxs;
`endif
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_wr_en = rx_push && (!rx_full || rx_pop);
  assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;

  // RX FIFO pointers and occupancy; a same-cycle pop makes room for a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + 1'b1;
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
      if (rx_wr_en && !rx_pop) rx_count <= rx_count + 1'b1;
      else if (!rx_wr_en && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr] <= rx_shift;
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (ferr_set) frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;
`ifdef UART_PARITY_EN
      if (perr_set) parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
`endif
    end
  end

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign tx_ready = !tx_full;
  assign tx_wr_en = tx_valid && tx_ready;
  assign tx_busy  = !tx_empty || (tx_state != T_IDLE);

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_wr_en) tx_wr <= tx_wr + 1'b1;
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
      if (tx_wr_en && !tx_pop) tx_count <= tx_count + 1'b1;
      else if (!tx_wr_en && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_wr_en) tx_mem[tx_wr] <= tx_data;
  end

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= T_IDLE;
    else tx_state <= tx_next;
  end

  // TX next-state: a queued byte follows the stop bit with no idle gap
  always_comb begin
    tx_next   = tx_state;
    tx_pop    = 1'b0;
    tx_at_end = tick && (tx_cnt == OS_LAST);
    case (tx_state)
      T_IDLE: begin
        if (tick && !tx_empty) begin
          tx_pop  = 1'b1;
          tx_next = T_START;
        end
      end
      T_START:  if (tx_at_end) tx_next = T_DATA;
      T_DATA: begin
        if (tx_at_end && tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
          tx_next = T_PARITY;
`else
          tx_next = T_STOP;
`endif
        end
      end
      T_PARITY: if (tx_at_end) tx_next = T_STOP;
      T_STOP: begin
        if (tx_at_end) begin
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_next = T_START;
          end else begin
            tx_next = T_IDLE;
          end
        end
      end
      default:  tx_next = T_IDLE;
    endcase
  end

  // TX datapath: registered line output updated only on bit boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_shift <= tx_mem[tx_rd];
`ifdef UART_PARITY_EN
      tx_par   <= ^tx_mem[tx_rd];
`endif
      tx_bit   <= '0;
      tx_cnt   <= '0;
      txd      <= 1'b0;
    end else if (tick && tx_state != T_IDLE) begin
      if (tx_at_end) begin
        tx_cnt <= '0;
        case (tx_state)
          T_START: txd <= tx_shift[0];
          T_DATA: begin
            if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              txd <= tx_par;
`else
              txd <= 1'b1;
`endif
            end else begin
              txd      <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end
          default: txd <= 1'b1;
        endcase
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed and randomized checks of uart_fifo_bridge against a queue-based model.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;

  localparam int CLK_HZ     = 1600000;
  localparam int BAUD       = 10000;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CLKS   = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd, tx_ready, tx_busy, rx_valid, frame_err, rx_overrun;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_line = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd;
`ifdef UART_PARITY_EN
  logic       parity_err;
`endif

  int         compare_count = 0;
  int         mismatch_count = 0;
  logic [7:0] exp_q[$];
  logic       model_frame_err = 1'b0;
  logic       model_overrun = 1'b0;

  assign rxd = loop_en ? txd : rx_line;

  always #5 clk = ~clk;

  uart_fifo_bridge #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .clr_err(clr_err), .frame_err(frame_err), .rx_overrun(rx_overrun)
`ifdef UART_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic holdLine(input logic level, input int clocks);
    rx_line = level;
    repeat (clocks) @(negedge clk);
  endtask

  // Drive one serial frame on the line and update the model
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
    holdLine(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) holdLine(value[i], BIT_CLKS);
    checkOutput("rx_no_early_push", rx_valid, exp_q.size() != 0);
    holdLine(stop_bit, BIT_CLKS);
    if (stop_bit) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(value);
      else model_overrun = 1'b1;
    end else begin
      model_frame_err = 1'b1;
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_frame_err"}, frame_err, model_frame_err);
    checkOutput({tag, "_overrun"}, rx_overrun, model_overrun);
  endtask

  task automatic drainAndCheck(input string tag);
    while (exp_q.size() > 0) begin
      checkOutput({tag, "_valid"}, rx_valid, 1'b1);
      checkOutput({tag, "_data"}, rx_data, exp_q.pop_front());
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    checkOutput({tag, "_empty"}, rx_valid, 1'b0);
  endtask

  task automatic pulseClear();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    model_frame_err = 1'b0;
    model_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitTxStart(output logic found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (txd == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("tx_start_seen", found, 1'b1);
  endtask

  task automatic writeTx(input logic [7:0] value);
    tx_valid = 1'b1;
    tx_data  = value;
    checkOutput("tx_ready_on_write", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        found;
    logic [19:0] exp_bits;
    int          lows;
    int          n;
    int          w;
    logic [7:0]  v;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_txd", txd, 1'b1);
    checkOutput("rst_tx_ready", tx_ready, 1'b1);
    checkOutput("rst_tx_busy", tx_busy, 1'b0);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_overrun", rx_overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Back-to-back TX of 0x55 then 0x0F with exact bit timing
    $display("[TB] TX back-to-back 0x55, 0x0F");
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(negedge clk);
    tx_data  = 8'h0F;
    @(negedge clk);
    tx_valid = 1'b0;
    exp_bits = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
    waitTxStart(found);
    if (found) begin
      for (int b = 0; b < 20; b++) begin
        checkOutput("tx_bit_head", txd, exp_bits[b]);
        repeat (BIT_CLKS - 1) @(negedge clk);
        checkOutput("tx_bit_tail", txd, exp_bits[b]);
        if (b == 19) checkOutput("tx_busy_in_last_stop", tx_busy, 1'b1);
        @(negedge clk);
      end
      checkOutput("tx_busy_after_stop", tx_busy, 1'b0);
      checkOutput("tx_idle_after_stop", txd, 1'b1);
    end

    // Reset in the middle of 0xA5 with another byte still queued
    $display("[TB] reset during TX of 0xA5");
    repeat (20) @(negedge clk);
    writeTx(8'hA5);
    writeTx(8'h5A);
    waitTxStart(found);
    repeat (BIT_CLKS * 4 + BIT_CLKS / 2) @(negedge clk);
    checkOutput("tx_pre_reset_bit3", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_txd", txd, 1'b1);
    checkOutput("mid_rst_tx_ready", tx_ready, 1'b1);
    checkOutput("mid_rst_tx_busy", tx_busy, 1'b0);
    checkOutput("mid_rst_rx_valid", rx_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (txd == 1'b0) lows++;
    end
    checkOutput("no_frame_after_reset", lows, 0);
    checkOutput("busy_after_reset", tx_busy, 1'b0);

    // Plain RX frame held in the FIFO
    $display("[TB] RX 0xC3");
    applyStimulus(8'hC3, 1'b1);
    checkFlags("rx_c3");
    drainAndCheck("rx_c3");

    // Short low pulse rejected as a false start
    $display("[TB] RX glitch then 0x3C");
    holdLine(1'b0, 40);
    holdLine(1'b1, 300);
    checkOutput("glitch_no_push", rx_valid, 1'b0);
    checkFlags("glitch");
    applyStimulus(8'h3C, 1'b1);
    checkFlags("rx_3c");
    drainAndCheck("rx_3c");

    // Framing error with break, recovery, then clear
    $display("[TB] RX framing error then 0x34");
    applyStimulus(8'h12, 1'b0);
    holdLine(1'b0, 500);
    holdLine(1'b1, 320);
    checkOutput("ferr_no_push", rx_valid, 1'b0);
    checkFlags("ferr");
    applyStimulus(8'h34, 1'b1);
    checkFlags("after_ferr");
    drainAndCheck("rx_34");
    pulseClear();
    checkFlags("ferr_cleared");

    // Overrun: nine frames into an eight-entry FIFO
    $display("[TB] RX overrun");
    for (int i = 1; i <= 9; i++) begin
      v = 8'(i);
      applyStimulus(v, 1'b1);
      if (i == 8 || i == 9) checkFlags("overrun_step");
    end
    drainAndCheck("overrun_drain");
    checkFlags("overrun_held");
    pulseClear();
    checkFlags("overrun_cleared");

    // Random RX bytes with random idle gaps
    $display("[TB] RX random");
    n = $urandom_range(3, 6);
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom_range(0, 255));
      applyStimulus(v, 1'b1);
      holdLine(1'b1, $urandom_range(0, 200));
    end
    checkFlags("rx_random");
    drainAndCheck("rx_random");

    // Random TX bytes looped back into RX
    $display("[TB] loopback random");
    loop_en = 1'b1;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      writeTx(v);
    end
    w = 0;
    while (tx_busy && w < 20000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("loop_tx_done", tx_busy, 1'b0);
    repeat (40) @(negedge clk);
    loop_en = 1'b0;
    checkFlags("loop");
    drainAndCheck("loop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
